// File: rtl/cv32e40x_ex_wb_queue_pkg.sv
// Shared constants for the EX/WB completion queue slice.
// Functional-unit indices select bits of every per-unit vector.
package cv32e40x_ex_wb_queue_pkg;

   localparam int FU_ALU         = 0;
   localparam int FU_MUL         = 1;
   localparam int FU_DIV         = 2;
   localparam int NUM_FU_DEFAULT = 3;

endpackage

// File: rtl/cv32e40x_ex_wb_queue_if.sv
// Issue, completion, writeback and forwarding bundle of the EX/WB queue.
// slave is the queue itself, master is its environment.
interface cv32e40x_ex_wb_queue_if
   import cv32e40x_ex_wb_queue_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int NUM_FU = NUM_FU_DEFAULT,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = $clog2(DEPTH + 1)
);

   logic                   issue_valid_i;
   logic                   issue_ready_o;
   logic [NUM_FU-1:0]      issue_fu_i;
   logic                   issue_we_i;
   logic [4:0]             issue_waddr_i;
   logic [NUM_FU-1:0]      fu_valid_i;
   logic [NUM_FU-1:0]      fu_ready_o;
   logic [NUM_FU*XLEN-1:0] fu_wdata_i;
   logic                   wb_valid_o;
   logic                   wb_ready_i;
   logic                   wb_we_o;
   logic [4:0]             wb_waddr_o;
   logic [XLEN-1:0]        wb_wdata_o;
   logic [4:0]             fwd_raddr_i;
   logic                   fwd_hit_o;
   logic                   fwd_pending_o;
   logic [XLEN-1:0]        fwd_wdata_o;
   logic                   flush_i;
   logic [CNT_W-1:0]       count_o;

   modport master (
      output issue_valid_i, issue_fu_i, issue_we_i, issue_waddr_i,
      output fu_valid_i, fu_wdata_i, wb_ready_i, fwd_raddr_i, flush_i,
      input  issue_ready_o, fu_ready_o, wb_valid_o, wb_we_o,
      input  wb_waddr_o, wb_wdata_o, fwd_hit_o, fwd_pending_o,
      input  fwd_wdata_o, count_o
   );

   modport slave (
      input  issue_valid_i, issue_fu_i, issue_we_i, issue_waddr_i,
      input  fu_valid_i, fu_wdata_i, wb_ready_i, fwd_raddr_i, flush_i,
      output issue_ready_o, fu_ready_o, wb_valid_o, wb_we_o,
      output wb_waddr_o, wb_wdata_o, fwd_hit_o, fwd_pending_o,
      output fwd_wdata_o, count_o
   );

endinterface

// File: rtl/cv32e40x_ex_wb_queue_find.sv
// Rotating priority finder: first set request walking up from i_base
// (oldest) or down from i_base-1 (youngest); one-hot result plus found.
module cv32e40x_ex_wb_queue_find #(
   parameter int DEPTH    = 4,
   parameter bit YOUNGEST = 1'b0
) (
   input  logic [DEPTH-1:0]         i_req,
   input  logic [$clog2(DEPTH)-1:0] i_base,
   output logic [DEPTH-1:0]         o_onehot,
   output logic                     o_found
);

   localparam int IW = $clog2(DEPTH);

   logic [IW-1:0] w_idx;

   always_comb begin
      o_onehot = '0;
      o_found  = 1'b0;
      w_idx    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_idx = YOUNGEST ? i_base - IW'(i + 1) : i_base + IW'(i);
         if (!o_found && i_req[w_idx]) begin
            o_onehot[w_idx] = 1'b1;
            o_found         = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cv32e40x_ex_wb_queue.sv
// In-order completion queue between EX functional units and WB,
// with per-unit completion targeting and youngest-match forwarding.
module cv32e40x_ex_wb_queue
   import cv32e40x_ex_wb_queue_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int NUM_FU = NUM_FU_DEFAULT,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input logic                   clk,
   input logic                   rst_n,
   cv32e40x_ex_wb_queue_if.slave bus
);

   localparam int IW = $clog2(DEPTH);
   localparam int FW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

   typedef struct packed {
      logic            valid;
      logic            done;
      logic [FW-1:0]   fu;
      logic            we;
      logic [4:0]      waddr;
      logic [XLEN-1:0] wdata;
   } entry_t;

   entry_t           r_q [DEPTH];
   logic [IW:0]      r_head;
   logic [IW:0]      r_tail;

   logic [IW-1:0]    w_hidx;
   logic [IW-1:0]    w_tidx;
   logic             w_full;
   logic             w_issue;
   logic             w_retire;
   logic             w_wb_valid;
   logic [FW-1:0]    w_fu_idx;
   logic [DEPTH-1:0] w_creq  [NUM_FU];
   logic [DEPTH-1:0] w_csel  [NUM_FU];
   logic [NUM_FU-1:0] w_cfound;
   logic [DEPTH-1:0] w_freq;
   logic [DEPTH-1:0] w_fsel;
   logic             w_ffound;
   logic             w_fdone;
   logic [XLEN-1:0]  w_fdata;

   assign w_hidx     = r_head[IW-1:0];
   assign w_tidx     = r_tail[IW-1:0];
   assign w_full     = (w_hidx == w_tidx) && (r_head[IW] != r_tail[IW]);
   assign w_issue    = bus.issue_valid_i & ~w_full;
   assign w_wb_valid = r_q[w_hidx].valid & r_q[w_hidx].done;
   assign w_retire   = w_wb_valid & bus.wb_ready_i;

   assign bus.issue_ready_o = ~w_full;
   assign bus.fu_ready_o    = w_cfound;
   assign bus.wb_valid_o    = w_wb_valid;
   assign bus.wb_we_o       = w_wb_valid & r_q[w_hidx].we;
   assign bus.wb_waddr_o    = w_wb_valid ? r_q[w_hidx].waddr : '0;
   assign bus.wb_wdata_o    = w_wb_valid ? r_q[w_hidx].wdata : '0;
   assign bus.count_o       = CNT_W'(r_tail - r_head);

   always_comb begin
      w_fu_idx = '0;
      for (int k = 0; k < NUM_FU; k++)
         if (bus.issue_fu_i[k]) w_fu_idx = FW'(k);
   end

   always_comb begin
      w_creq = '{default: '0};
      w_freq = '0;
      for (int e = 0; e < DEPTH; e++) begin
         for (int k = 0; k < NUM_FU; k++)
            w_creq[k][e] = r_q[e].valid & ~r_q[e].done
                         & (r_q[e].fu == FW'(k));
         w_freq[e] = r_q[e].valid & r_q[e].we
                   & (r_q[e].waddr == bus.fwd_raddr_i)
                   & (bus.fwd_raddr_i != 5'd0);
      end
   end

   for (genvar k = 0; k < NUM_FU; k++) begin : g_cfind
      cv32e40x_ex_wb_queue_find #(
         .DEPTH    (DEPTH),
         .YOUNGEST (1'b0)
      ) u_find (
         .i_req    (w_creq[k]),
         .i_base   (w_hidx),
         .o_onehot (w_csel[k]),
         .o_found  (w_cfound[k])
      );
   end

   cv32e40x_ex_wb_queue_find #(
      .DEPTH    (DEPTH),
      .YOUNGEST (1'b1)
   ) u_ffind (
      .i_req    (w_freq),
      .i_base   (w_tidx),
      .o_onehot (w_fsel),
      .o_found  (w_ffound)
   );

   always_comb begin
      w_fdone = 1'b0;
      w_fdata = '0;
      for (int e = 0; e < DEPTH; e++)
         if (w_fsel[e]) begin
            w_fdone = r_q[e].done;
            w_fdata = r_q[e].wdata;
         end
   end

   assign bus.fwd_hit_o     = w_ffound & w_fdone;
   assign bus.fwd_pending_o = w_ffound & ~w_fdone;
   assign bus.fwd_wdata_o   = (w_ffound & w_fdone) ? w_fdata : '0;

   // Flush wins over any same-cycle issue, completion or retire.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head <= '0;
         r_tail <= '0;
         for (int e = 0; e < DEPTH; e++) r_q[e] <= '0;
      end else if (bus.flush_i) begin
         r_head <= '0;
         r_tail <= '0;
         for (int e = 0; e < DEPTH; e++) r_q[e].valid <= 1'b0;
      end else begin
         for (int k = 0; k < NUM_FU; k++)
            for (int e = 0; e < DEPTH; e++)
               if (bus.fu_valid_i[k] & w_csel[k][e]) begin
                  r_q[e].done  <= 1'b1;
                  r_q[e].wdata <= bus.fu_wdata_i[k*XLEN +: XLEN];
               end
         if (w_retire) begin
            r_q[w_hidx].valid <= 1'b0;
            r_head            <= r_head + 1'b1;
         end
         if (w_issue) begin
            r_q[w_tidx].valid <= 1'b1;
            r_q[w_tidx].done  <= 1'b0;
            r_q[w_tidx].fu    <= w_fu_idx;
            r_q[w_tidx].we    <= bus.issue_we_i;
            r_q[w_tidx].waddr <= bus.issue_waddr_i;
            r_q[w_tidx].wdata <= '0;
            r_tail            <= r_tail + 1'b1;
         end
      end
   end

   a_fu_onehot: assert property (@(posedge clk) disable iff (!rst_n)
      bus.issue_valid_i |-> $onehot(bus.issue_fu_i));

   a_fu_drop: assert property (@(posedge clk) disable iff (!rst_n)
      (bus.fu_valid_i & ~w_cfound) == '0);

endmodule

// File: tb/tb_cv32e40x_ex_wb_queue.sv
// Bench for the EX/WB completion queue: directed scenarios plus a
// randomized run against a program-order queue model.
module tb_cv32e40x_ex_wb_queue;
   import cv32e40x_ex_wb_queue_pkg::*;

   localparam int XLEN   = 32;
   localparam int NUM_FU = 3;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = $clog2(DEPTH + 1);

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cv32e40x_ex_wb_queue_if #(
      .XLEN(XLEN), .NUM_FU(NUM_FU), .DEPTH(DEPTH), .CNT_W(CNT_W)
   ) bus ();

   cv32e40x_ex_wb_queue #(
      .XLEN(XLEN), .NUM_FU(NUM_FU), .DEPTH(DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int              fu;
      bit              we;
      logic [4:0]      waddr;
      bit              done;
      logic [XLEN-1:0] data;
   } mdl_t;

   mdl_t mq[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   logic              e_issue_ready;
   logic [NUM_FU-1:0] e_fu_ready;
   logic              e_wb_valid;
   logic              e_wb_we;
   logic [4:0]        e_wb_waddr;
   logic [XLEN-1:0]   e_wb_wdata;
   logic              e_hit;
   logic              e_pend;
   logic [XLEN-1:0]   e_fdata;
   logic [CNT_W-1:0]  e_count;

   // Expected outputs from the program-order list of in-flight instructions.
   task automatic model_eval();
      e_issue_ready = mq.size() < DEPTH;
      e_fu_ready    = '0;
      foreach (mq[i]) if (!mq[i].done) e_fu_ready[mq[i].fu] = 1'b1;
      e_wb_valid = (mq.size() > 0) && mq[0].done;
      e_wb_we    = e_wb_valid ? mq[0].we : 1'b0;
      e_wb_waddr = e_wb_valid ? mq[0].waddr : 5'd0;
      e_wb_wdata = e_wb_valid ? mq[0].data : '0;
      e_hit   = 1'b0;
      e_pend  = 1'b0;
      e_fdata = '0;
      if (bus.fwd_raddr_i != 5'd0)
         for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].we && mq[i].waddr == bus.fwd_raddr_i) begin
               e_hit   = mq[i].done;
               e_pend  = !mq[i].done;
               e_fdata = mq[i].done ? mq[i].data : '0;
               break;
            end
      e_count = CNT_W'(mq.size());
   endtask

   task automatic model_step();
      bit   ret;
      bit   iss;
      mdl_t m;
      if (bus.flush_i) begin
         mq.delete();
         return;
      end
      ret = e_wb_valid && bus.wb_ready_i;
      iss = bus.issue_valid_i && (mq.size() < DEPTH);
      for (int k = 0; k < NUM_FU; k++)
         if (bus.fu_valid_i[k])
            for (int i = 0; i < mq.size(); i++)
               if (mq[i].fu == k && !mq[i].done) begin
                  mq[i].done = 1'b1;
                  mq[i].data = bus.fu_wdata_i[k*XLEN +: XLEN];
                  break;
               end
      if (ret) void'(mq.pop_front());
      if (iss) begin
         m.fu = 0;
         for (int k = 0; k < NUM_FU; k++) if (bus.issue_fu_i[k]) m.fu = k;
         m.we    = bus.issue_we_i;
         m.waddr = bus.issue_waddr_i;
         m.done  = 1'b0;
         m.data  = '0;
         mq.push_back(m);
      end
   endtask

   task automatic tick();
      model_eval();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.issue_valid_i = 1'b0;
      bus.issue_fu_i    = 3'b001;
      bus.issue_we_i    = 1'b0;
      bus.issue_waddr_i = 5'd0;
      bus.fu_valid_i    = '0;
      bus.fu_wdata_i    = '0;
      bus.wb_ready_i    = 1'b1;
      bus.fwd_raddr_i   = 5'd0;
      bus.flush_i       = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      mq.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic set_issue(input int fu, input bit we, input int addr);
      bus.issue_valid_i = 1'b1;
      bus.issue_fu_i    = NUM_FU'(1 << fu);
      bus.issue_we_i    = we;
      bus.issue_waddr_i = addr[4:0];
   endtask

   task automatic set_done(input int k, input logic [XLEN-1:0] d);
      bus.fu_valid_i[k]              = 1'b1;
      bus.fu_wdata_i[k*XLEN +: XLEN] = d;
   endtask

   task automatic test_reset();
      do_reset();
      bus.fwd_raddr_i = 5'd5;
      @(negedge clk);
      n_chk++;
      if (bus.issue_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_issue_ready got=%b exp=1", bus.issue_ready_o);
      end
      n_chk++;
      if (bus.wb_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_wb_valid got=%b exp=0", bus.wb_valid_o);
      end
      n_chk++;
      if (bus.count_o !== '0) begin
         n_fail++;
         $display("FAIL rst_count got=%0d exp=0", bus.count_o);
      end
      n_chk++;
      if (bus.fu_ready_o !== '0) begin
         n_fail++;
         $display("FAIL rst_fu_ready got=%b exp=000", bus.fu_ready_o);
      end
      n_chk++;
      if ({bus.wb_we_o, bus.wb_waddr_o, bus.wb_wdata_o} !== '0) begin
         n_fail++;
         $display("FAIL rst_wb_fields got=%b/%0d/%h exp=0/0/0",
                  bus.wb_we_o, bus.wb_waddr_o, bus.wb_wdata_o);
      end
      n_chk++;
      if ({bus.fwd_hit_o, bus.fwd_pending_o, bus.fwd_wdata_o} !== '0) begin
         n_fail++;
         $display("FAIL rst_fwd got=%b/%b/%h exp=0/0/0",
                  bus.fwd_hit_o, bus.fwd_pending_o, bus.fwd_wdata_o);
      end
      tick();
      for (int i = 0; i < DEPTH; i++) begin
         idle();
         set_issue(FU_DIV, 1'b1, i + 1);
         tick();
      end
      idle();
      set_issue(FU_ALU, 1'b1, 20);
      @(negedge clk);
      n_chk++;
      if (bus.issue_ready_o !== 1'b0) begin
         n_fail++;
         $display("FAIL full_issue_ready got=%b exp=0", bus.issue_ready_o);
      end
      n_chk++;
      if (bus.count_o !== CNT_W'(DEPTH)) begin
         n_fail++;
         $display("FAIL full_count got=%0d exp=%0d", bus.count_o, DEPTH);
      end
      tick();
      idle();
      @(negedge clk);
      n_chk++;
      if (bus.count_o !== CNT_W'(DEPTH) || bus.fu_ready_o !== 3'b100) begin
         n_fail++;
         $display("FAIL full_refused got=%0d/%b exp=%0d/100",
                  bus.count_o, bus.fu_ready_o, DEPTH);
      end
      tick();
   endtask

   task automatic test_out_of_order();
      int              first;
      int              nret;
      logic [4:0]      ra [2];
      logic [XLEN-1:0] rd [2];
      first = -1;
      nret  = 0;
      do_reset();
      for (int c = 0; c < 12; c++) begin
         idle();
         if (c == 0) set_issue(FU_DIV, 1'b1, 5);
         if (c == 1) set_issue(FU_ALU, 1'b1, 6);
         if (c == 2) set_done(FU_ALU, 32'h11);
         if (c == 6) set_done(FU_DIV, 32'h22);
         @(negedge clk);
         model_eval();
         n_chk++;
         if (bus.wb_valid_o !== e_wb_valid) begin
            n_fail++;
            $display("FAIL ooo_wb_valid c=%0d got=%b exp=%b",
                     c, bus.wb_valid_o, e_wb_valid);
         end
         if (c == 2) begin
            n_chk++;
            if (bus.fu_ready_o !== 3'b101) begin
               n_fail++;
               $display("FAIL ooo_fu_ready got=%b exp=101", bus.fu_ready_o);
            end
         end
         if (bus.wb_valid_o === 1'b1 && nret < 2) begin
            if (first < 0) first = c;
            ra[nret] = bus.wb_waddr_o;
            rd[nret] = bus.wb_wdata_o;
            nret++;
         end
         tick();
      end
      n_chk++;
      if (first != 7 || nret != 2) begin
         n_fail++;
         $display("FAIL ooo_first_retire got=%0d/%0d exp=7/2", first, nret);
      end else begin
         n_chk++;
         if (ra[0] !== 5'd5 || rd[0] !== 32'h22) begin
            n_fail++;
            $display("FAIL ooo_retire0 got=x%0d=%h exp=x5=22", ra[0], rd[0]);
         end
         n_chk++;
         if (ra[1] !== 5'd6 || rd[1] !== 32'h11) begin
            n_fail++;
            $display("FAIL ooo_retire1 got=x%0d=%h exp=x6=11", ra[1], rd[1]);
         end
      end
   endtask

   task automatic test_forward();
      do_reset();
      set_issue(FU_MUL, 1'b1, 7);
      tick();
      idle();
      set_issue(FU_ALU, 1'b1, 7);
      tick();
      idle();
      set_done(FU_ALU, 32'hAA);
      tick();
      idle();
      bus.fwd_raddr_i = 5'd7;
      @(negedge clk);
      n_chk++;
      if (bus.fwd_hit_o !== 1'b1 || bus.fwd_pending_o !== 1'b0) begin
         n_fail++;
         $display("FAIL fwd_hit got=%b/%b exp=1/0",
                  bus.fwd_hit_o, bus.fwd_pending_o);
      end
      n_chk++;
      if (bus.fwd_wdata_o !== 32'hAA) begin
         n_fail++;
         $display("FAIL fwd_data got=%h exp=aa", bus.fwd_wdata_o);
      end
      bus.fwd_raddr_i = 5'd0;
      #1;
      n_chk++;
      if ({bus.fwd_hit_o, bus.fwd_pending_o, bus.fwd_wdata_o} !== '0) begin
         n_fail++;
         $display("FAIL fwd_x0 got=%b/%b/%h exp=0/0/0",
                  bus.fwd_hit_o, bus.fwd_pending_o, bus.fwd_wdata_o);
      end
      bus.fwd_raddr_i = 5'd8;
      #1;
      n_chk++;
      if ({bus.fwd_hit_o, bus.fwd_pending_o, bus.fwd_wdata_o} !== '0) begin
         n_fail++;
         $display("FAIL fwd_nomatch got=%b/%b/%h exp=0/0/0",
                  bus.fwd_hit_o, bus.fwd_pending_o, bus.fwd_wdata_o);
      end
      tick();
   endtask

   task automatic test_pending_backpressure();
      do_reset();
      set_issue(FU_MUL, 1'b1, 9);
      tick();
      idle();
      bus.fwd_raddr_i = 5'd9;
      @(negedge clk);
      n_chk++;
      if (bus.fwd_pending_o !== 1'b1 || bus.fwd_hit_o !== 1'b0) begin
         n_fail++;
         $display("FAIL fwd_pending got=%b/%b exp=1/0",
                  bus.fwd_pending_o, bus.fwd_hit_o);
      end
      set_done(FU_MUL, 32'h99);
      set_issue(FU_ALU, 1'b0, 4);
      #1;
      n_chk++;
      if (bus.fwd_pending_o !== 1'b1 || bus.fwd_hit_o !== 1'b0) begin
         n_fail++;
         $display("FAIL fwd_no_bypass got=%b/%b exp=1/0",
                  bus.fwd_pending_o, bus.fwd_hit_o);
      end
      tick();
      idle();
      bus.wb_ready_i = 1'b0;
      set_done(FU_ALU, 32'h33);
      tick();
      for (int i = 0; i < 3; i++) begin
         idle();
         bus.wb_ready_i = 1'b0;
         @(negedge clk);
         n_chk++;
         if (bus.wb_valid_o !== 1'b1 || bus.wb_waddr_o !== 5'd9 ||
             bus.wb_wdata_o !== 32'h99 || bus.count_o !== CNT_W'(2)) begin
            n_fail++;
            $display("FAIL bp_hold i=%0d got=%b/x%0d/%h/%0d exp=1/x9/99/2",
                     i, bus.wb_valid_o, bus.wb_waddr_o,
                     bus.wb_wdata_o, bus.count_o);
         end
         tick();
      end
      idle();
      tick();
      idle();
      @(negedge clk);
      n_chk++;
      if (bus.wb_valid_o !== 1'b1 || bus.wb_we_o !== 1'b0 ||
          bus.wb_wdata_o !== 32'h33) begin
         n_fail++;
         $display("FAIL we0_retire got=%b/%b/%h exp=1/0/33",
                  bus.wb_valid_o, bus.wb_we_o, bus.wb_wdata_o);
      end
      tick();
      @(negedge clk);
      n_chk++;
      if (bus.count_o !== '0 || bus.wb_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_drain got=%0d/%b exp=0/0",
                  bus.count_o, bus.wb_valid_o);
      end
      tick();
   endtask

   task automatic test_flush();
      do_reset();
      set_issue(FU_ALU, 1'b1, 1);
      tick();
      idle();
      set_issue(FU_MUL, 1'b1, 2);
      set_done(FU_ALU, 32'h1);
      tick();
      idle();
      @(negedge clk);
      n_chk++;
      if (bus.wb_valid_o !== 1'b1 || bus.fu_ready_o !== 3'b010) begin
         n_fail++;
         $display("FAIL flush_pre got=%b/%b exp=1/010",
                  bus.wb_valid_o, bus.fu_ready_o);
      end
      bus.flush_i = 1'b1;
      set_issue(FU_ALU, 1'b1, 3);
      set_done(FU_MUL, 32'h2);
      tick();
      idle();
      @(negedge clk);
      n_chk++;
      if (bus.count_o !== '0 || bus.issue_ready_o !== 1'b1 ||
          bus.fu_ready_o !== '0) begin
         n_fail++;
         $display("FAIL flush_state got=%0d/%b/%b exp=0/1/000",
                  bus.count_o, bus.issue_ready_o, bus.fu_ready_o);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_chk++;
         if (bus.wb_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_no_wb i=%0d got=%b exp=0", i, bus.wb_valid_o);
         end
         tick();
      end
   endtask

   task automatic test_wrap_random();
      int nret;
      nret = 0;
      do_reset();
      for (int c = 0; c < 300; c++) begin
         idle();
         model_eval();
         if ($urandom_range(0, 1) != 0)
            set_issue($urandom_range(0, NUM_FU - 1), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 7));
         for (int k = 0; k < NUM_FU; k++)
            if (e_fu_ready[k] && $urandom_range(0, 2) != 0)
               set_done(k, $urandom);
         bus.wb_ready_i  = ($urandom_range(0, 3) != 0);
         bus.fwd_raddr_i = 5'($urandom_range(0, 7));
         bus.flush_i     = ($urandom_range(0, 59) == 0);
         @(negedge clk);
         model_eval();
         n_chk++;
         if (bus.issue_ready_o !== e_issue_ready ||
             bus.count_o !== e_count) begin
            n_fail++;
            $display("FAIL rnd_occ c=%0d got=%b/%0d exp=%b/%0d", c,
                     bus.issue_ready_o, bus.count_o, e_issue_ready, e_count);
         end
         n_chk++;
         if (bus.fu_ready_o !== e_fu_ready) begin
            n_fail++;
            $display("FAIL rnd_fu_ready c=%0d got=%b exp=%b",
                     c, bus.fu_ready_o, e_fu_ready);
         end
         n_chk++;
         if ({bus.wb_valid_o, bus.wb_we_o, bus.wb_waddr_o, bus.wb_wdata_o} !==
             {e_wb_valid, e_wb_we, e_wb_waddr, e_wb_wdata}) begin
            n_fail++;
            $display("FAIL rnd_wb c=%0d got=%b/%b/x%0d/%h exp=%b/%b/x%0d/%h",
                     c, bus.wb_valid_o, bus.wb_we_o, bus.wb_waddr_o,
                     bus.wb_wdata_o, e_wb_valid, e_wb_we, e_wb_waddr,
                     e_wb_wdata);
         end
         n_chk++;
         if ({bus.fwd_hit_o, bus.fwd_pending_o, bus.fwd_wdata_o} !==
             {e_hit, e_pend, e_fdata}) begin
            n_fail++;
            $display("FAIL rnd_fwd c=%0d got=%b/%b/%h exp=%b/%b/%h", c,
                     bus.fwd_hit_o, bus.fwd_pending_o, bus.fwd_wdata_o,
                     e_hit, e_pend, e_fdata);
         end
         if (e_wb_valid && bus.wb_ready_i && !bus.flush_i) nret++;
         tick();
      end
      n_chk++;
      if (nret <= 3 * DEPTH) begin
         n_fail++;
         $display("FAIL rnd_retires got=%0d exp>%0d", nret, 3 * DEPTH);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_out_of_order();
      test_forward();
      test_pending_backpressure();
      test_flush();
      test_wrap_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
